ahb3lite_sram_slave: RTL
========================

Name: ahb3lite_sram_slave

Overview:
- AHB-Lite responder backing an on-chip word-organised SRAM. It is the completion end of the CPU/DMA burst master adapter.
- Samples address phases, services read and write data phases with a configurable number of wait states, and converts illegal accesses into the two-cycle ERROR response.
- Sits behind the interconnect decoder and mux, alongside other peripheral slaves.

Parameters:
- MEM_WORDS, 1024, SRAM depth in 32-bit words. Must be a power of 2; byte size is MEM_WORDS*4.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before every OKAY data phase. Legal range 0..7.

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  000 byte, 001 half, 010 word.
- HBURST  in  3  burst type; informational only.
- HWSTRB  in  4  write byte strobes, address-phase signal.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready from the mux.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset (async, HRESET=1): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, pending write discarded, wait counter=0. SRAM contents are not cleared.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. The slave registers addr, write, size and lanes.
- No-access cases: IDLE or BUSY transfers, or HSEL=0. The next data phase is OKAY with zero wait and no SRAM access.
- Addressing: SEQ is treated identically to NONSEQ. The address is always taken from HADDR; HBURST is ignored, and no internal address increment is performed.
- Lane decode: lanes = f(HSIZE, HADDR[1:0]).
  - byte: 1<<HADDR[1:0]
  - half: 0011 or 1100 by HADDR[1]
  - word: 1111
- Error conditions, any of:
  - HADDR >= MEM_WORDS*4
  - HSIZE > 010
  - half access at odd address
  - word access not 4-aligned
  - write with HWSTRB != lanes
- States:
  - IDLE: no data phase pending; HREADYOUT=1, HRESP=0.
  - WAIT: counter runs WAIT_STATES..1; HREADYOUT=0, HRESP=0.
  - DATA: HREADYOUT=1, HRESP=0. Reads present data; writes commit HWDATA lanes at this edge.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1; HRDATA=0.
- Transitions:
  - Legal accept with WAIT_STATES=0 -> DATA.
  - Legal accept with WAIT_STATES>0 -> WAIT, then DATA.
  - Illegal accept -> ERR1 -> ERR2. WAIT_STATES does not apply to errors.
  - From DATA or ERR2: a new accept in the same cycle (HREADY=1) chains directly to its next state. Otherwise -> IDLE.
  - A new address phase is never sampled while HREADYOUT=0.
- Read latency: the SRAM is read at the accept edge. HRDATA holds the word (all 32 bits; the master selects the lanes) from the first HREADYOUT=1 cycle of that data phase.
- Read-after-write hazard: a write data phase is followed back-to-back by a read accept to the same word. The committed write lanes are merged into HRDATA, so the read returns the new data.
- Errored writes never modify the SRAM. An errored read returns HRDATA=0.
- Reset asserted mid data phase: the write is dropped, and all outputs go to their reset values immediately, asynchronously.
- HRDATA holds its last value outside read data phases. It is 0 after reset and after an ERR2.

Test Plan:
- Word write of 0xDEADBEEF at 0x010 (WAIT_STATES=0), then word read at 0x010 -> HREADYOUT never low, HRESP=0, HRDATA=0xDEADBEEF.
- Write byte 0xAA at 0x011 and half 0x5566 at 0x012 over word 0x00000000, then read 0x010 -> 0x5566AA00.
- Back-to-back write 0x12345678 @0x020 then read @0x020 with no idle cycle -> HRDATA=0x12345678 via forwarding.
- WAIT_STATES=2, INCR4 read from 0x040 (NONSEQ+3 SEQ, HADDR 0x40/44/48/4C) -> each beat has HREADYOUT low for 2 cycles then high; the 4 words are returned in order.
- Word read at 0x002, and write at MEM_WORDS*4 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1, 1). Memory is unchanged and HRDATA=0.
- Assert HRESET during the WAIT of a write 0xCAFEF00D @0x030 -> outputs reset at once; a later read @0x030 returns the prior contents.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
// AHB-Lite responder in front of a word-organised on-chip SRAM. Address
// phases are sampled when HSEL & HREADY & HTRANS[1]; each legal data phase
// gets WAIT_STATES low-ready cycles and then an OKAY completion. Illegal
// accesses get the two-cycle ERROR response and never touch the array.
//
// Ports
//   HCLK       in   1   bus clock, rising edge
//   HRESET     in   1   asynchronous active-high reset
//   HSEL       in   1   slave select from the decoder
//   HADDR      in  32   byte address
//   HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1   1 = write
//   HSIZE      in   3   byte/half/word
//   HBURST     in   3   burst type, ignored
//   HWSTRB     in   4   write byte strobes (address phase)
//   HWDATA     in  32   write data (data phase)
//   HREADY     in   1   bus-wide ready
//   HREADYOUT  out  1   this slave's ready
//   HRESP      out  1   0 = OKAY, 1 = ERROR
//   HRDATA     out 32   read data
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HWSTRB,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int unsigned WCW = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [AW-1:0]  r_idx;
  logic           r_write;
  logic [3:0]     r_lanes;
  logic [WCW-1:0] r_wait_cnt;
  logic [31:0]    r_hrdata;
  logic [31:0]    r_mem [MEM_WORDS];

  logic           w_slot_open;
  logic           w_accept;
  logic           w_oob;
  logic           w_misalign;
  logic           w_bad_strb;
  logic           w_illegal;
  logic           w_commit;
  logic           w_hit;
  logic [3:0]     w_lanes;
  logic [AW-1:0]  w_idx;
  logic [31:0]    w_rd_word;
  logic           w_unused;

  // HBURST and the SEQ/NONSEQ distinction carry no meaning for this slave
  assign w_unused = ^{HTRANS[0], HBURST};

  // Address phases are only taken in cycles where this slave shows ready
  assign w_slot_open = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept    = HSEL && HREADY && HTRANS[1] && w_slot_open;

  assign w_idx = HADDR[AW+1:2];

  // Byte lanes touched by the requested access
  always_comb begin
    w_lanes = 4'b0000;
    case (HSIZE)
      3'b000:  w_lanes = 4'b0001 << HADDR[1:0];
      3'b001:  w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_lanes = 4'b1111;
      default: w_lanes = 4'b0000;
    endcase
  end

  assign w_oob      = |HADDR[31:AW+2];
  assign w_misalign = ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign w_bad_strb = HWRITE && (HWSTRB != w_lanes);
  assign w_illegal  = w_oob || (HSIZE > 3'b010) || w_misalign || w_bad_strb;

  // Write data phase completing at this edge
  assign w_commit = (r_state == S_DATA) && r_write;
  assign w_hit    = w_commit && (r_idx == w_idx);

  // Array word for a read accept, with the lanes being written this cycle forwarded
  always_comb begin
    w_rd_word = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_hit && r_lanes[b]) begin
        w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!w_accept) begin
          w_next = S_IDLE;
        end else if (w_illegal) begin
          w_next = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          w_next = S_DATA;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt <= WCW'(1)) begin
          w_next = S_DATA;
        end
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  // Response outputs decoded from state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: ;
    endcase
  end

  assign HRDATA = r_hrdata;

  // Address-phase capture, wait counter and read data register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_lanes    <= 4'b0000;
      r_wait_cnt <= '0;
      r_hrdata   <= '0;
    end else begin
      if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - WCW'(1);
      end
      if (w_accept) begin
        if (w_illegal) begin
          r_write  <= 1'b0;
          r_hrdata <= '0;
        end else begin
          r_idx      <= w_idx;
          r_write    <= HWRITE;
          r_lanes    <= w_lanes;
          r_wait_cnt <= WCW'(WAIT_STATES);
          if (!HWRITE) begin
            r_hrdata <= w_rd_word;
          end
        end
      end
    end
  end

  // SRAM array; contents survive reset
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_lanes[b]) begin
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule
